// File: rtl/s6bit_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : s6bit_accumulator
// Purpose  : Batch accumulator for signed 6-bit operands. Takes N_OPS
//            operands over a valid/ready input handshake. Keeps a sticky
//            signed-overflow flag. Wraps or saturates the sum per step.
//            Holds the final result under a valid/ready output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module s6bit_accumulator #(
  parameter int N_OPS    = 4,
  parameter int CNT_W    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_data,
  output logic [5:0]       acc,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS);

  state_t           state;
  logic             xfer;
  logic [5:0]       raw_sum;
  logic             step_ovf;
  logic [5:0]       next_acc;
  logic [CNT_W-1:0] count_inc;

  // Input handshake: blocked while a result is held or a clear is pending.
  assign in_ready = (state != DONE) && !clear;
  assign xfer     = in_valid && in_ready;

  // Single-step 6-bit add with signed overflow detection and optional clamp.
  always_comb begin
    raw_sum   = acc + in_data;
    step_ovf  = (acc[5] == in_data[5]) && (raw_sum[5] != acc[5]);
    next_acc  = raw_sum;
    if (SATURATE && step_ovf) begin
      // Clamp towards the sign both operands shared.
      next_acc = acc[5] ? 6'b100000 : 6'b011111;
    end
    count_inc = count + 1'b1;
  end

  // Batch FSM with registered result, flag, count and out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      overflow  <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      // Abort drops any held result; a simultaneous out_ready does not deliver it.
      state     <= IDLE;
      acc       <= '0;
      overflow  <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (xfer) begin
            acc      <= next_acc;
            overflow <= overflow | step_ovf;
            count    <= count_inc;
            if (count_inc == LAST_CNT) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            overflow  <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          overflow  <= 1'b0;
          count     <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s6bit_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_s6bit_accumulator
// Purpose  : Directed, table-driven bench for s6bit_accumulator. A wrapping
//            and a saturating instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s6bit_accumulator;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_ready;

  logic       rdy0, rdy1, ov0, ov1, of0, of1;
  logic [5:0] acc0, acc1;
  logic [2:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  s6bit_accumulator #(.N_OPS(4), .CNT_W(3), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .acc(acc0), .overflow(of0), .count(cnt0),
    .out_valid(ov0), .out_ready(out_ready)
  );

  s6bit_accumulator #(.N_OPS(4), .CNT_W(3), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .acc(acc1), .overflow(of1), .count(cnt1),
    .out_valid(ov1), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [5:0] d;
    logic       ordy;
    logic       rdy;   // in_ready expected before the edge
    logic [5:0] a0;    // wrap instance acc after the edge
    logic       o0;
    logic [5:0] a1;    // saturating instance acc after the edge
    logic       o1;
    logic [2:0] cnt;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, input logic vld, input logic [5:0] d,
                     input logic ordy, input logic rdy,
                     input logic [5:0] a0, input logic o0,
                     input logic [5:0] a1, input logic o1,
                     input logic [2:0] cnt, input logic ov);
    vec_t v;
    v.clr = clr; v.vld = vld; v.d = d; v.ordy = ordy; v.rdy = rdy;
    v.a0 = a0; v.o0 = o0; v.a1 = a1; v.o1 = o1; v.cnt = cnt; v.ov = ov;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic [5:0] a0, input logic o0,
                           input logic [5:0] a1, input logic o1,
                           input logic [2:0] cnt, input logic ov);
    chk({tag, ".acc_wrap"}, 32'(acc0), 32'(a0));
    chk({tag, ".ovf_wrap"}, 32'(of0), 32'(o0));
    chk({tag, ".acc_sat"}, 32'(acc1), 32'(a1));
    chk({tag, ".ovf_sat"}, 32'(of1), 32'(o1));
    chk({tag, ".count"}, 32'(cnt0), 32'(cnt));
    chk({tag, ".count_sat"}, 32'(cnt1), 32'(cnt));
    chk({tag, ".out_valid"}, 32'(ov0), 32'(ov));
    chk({tag, ".out_valid_sat"}, 32'(ov1), 32'(ov));
  endtask

  task automatic drive(input logic clr, input logic vld, input logic [5:0] d, input logic ordy);
    clear = clr; in_valid = vld; in_data = d; out_ready = ordy;
  endtask

  initial begin
    // Plain batch 1,2,3,4 then handoff
    add(0,1,6'd1,0, 1, 6'd1,0, 6'd1,0, 3'd1,0);
    add(0,1,6'd2,0, 1, 6'd3,0, 6'd3,0, 3'd2,0);
    add(0,1,6'd3,0, 1, 6'd6,0, 6'd6,0, 3'd3,0);
    add(0,1,6'd4,0, 1, 6'd10,0, 6'd10,0, 3'd4,1);
    add(0,0,6'd0,1, 0, 6'd0,0, 6'd0,0, 3'd0,0);
    // Positive overflow: 20+15 wraps to -29, or clamps to +31
    add(0,1,6'd20,0, 1, 6'd20,0, 6'd20,0, 3'd1,0);
    add(0,1,6'd15,0, 1, 6'h23,1, 6'h1F,1, 3'd2,0);
    add(0,1,6'd0,0,  1, 6'h23,1, 6'h1F,1, 3'd3,0);
    add(0,1,6'd0,0,  1, 6'h23,1, 6'h1F,1, 3'd4,1);
    add(0,0,6'd0,1,  0, 6'd0,0, 6'd0,0, 3'd0,0);
    // Negative overflow: -32 + -1 wraps to 31, or clamps to -32
    add(0,1,6'h20,0, 1, 6'h20,0, 6'h20,0, 3'd1,0);
    add(0,1,6'h3F,0, 1, 6'h1F,1, 6'h20,1, 3'd2,0);
    add(0,1,6'h01,0, 1, 6'h20,1, 6'h21,1, 3'd3,0);
    add(0,1,6'h00,0, 1, 6'h20,1, 6'h21,1, 3'd4,1);
    add(0,0,6'd0,1,  0, 6'd0,0, 6'd0,0, 3'd0,0);
    // Result held under backpressure while in_valid pulses with 7
    add(0,1,6'd1,0, 1, 6'd1,0, 6'd1,0, 3'd1,0);
    add(0,1,6'd1,0, 1, 6'd2,0, 6'd2,0, 3'd2,0);
    add(0,1,6'd1,0, 1, 6'd3,0, 6'd3,0, 3'd3,0);
    add(0,1,6'd1,0, 1, 6'd4,0, 6'd4,0, 3'd4,1);
    for (int i = 0; i < 5; i++) add(0,(i % 2 == 0),6'd7,0, 0, 6'd4,0, 6'd4,0, 3'd4,1);
    add(0,1,6'd7,1, 0, 6'd0,0, 6'd0,0, 3'd0,0);
    add(0,1,6'd7,0, 1, 6'd7,0, 6'd7,0, 3'd1,0);
    // Clear mid-batch, then clear colliding with an operand
    add(1,0,6'd0,0, 0, 6'd0,0, 6'd0,0, 3'd0,0);
    add(0,1,6'd2,0, 1, 6'd2,0, 6'd2,0, 3'd1,0);
    add(0,1,6'd3,0, 1, 6'd5,0, 6'd5,0, 3'd2,0);
    add(1,1,6'd9,0, 0, 6'd0,0, 6'd0,0, 3'd0,0);
    add(0,0,6'd9,0, 1, 6'd0,0, 6'd0,0, 3'd0,0);
    // Clear in DONE with out_ready: result discarded
    add(0,1,6'd2,0, 1, 6'd2,0, 6'd2,0, 3'd1,0);
    add(0,1,6'd2,0, 1, 6'd4,0, 6'd4,0, 3'd2,0);
    add(0,1,6'd2,0, 1, 6'd6,0, 6'd6,0, 3'd3,0);
    add(0,1,6'd2,0, 1, 6'd8,0, 6'd8,0, 3'd4,1);
    add(1,0,6'd0,1, 0, 6'd0,0, 6'd0,0, 3'd0,0);
    add(0,0,6'd0,0, 1, 6'd0,0, 6'd0,0, 3'd0,0);

    // Reset state
    drive(0,0,6'd0,0);
    rst = 1'b1;
    #1;
    chk_state("reset", 6'd0,0, 6'd0,0, 3'd0,0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.in_ready", 32'(rdy0), 32'd1);

    // Table-driven cycles
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].clr, vecs[i].vld, vecs[i].d, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(rdy0), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.in_ready_sat", i), 32'(rdy1), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].a0, vecs[i].o0, vecs[i].a1,
                vecs[i].o1, vecs[i].cnt, vecs[i].ov);
    end

    // Asynchronous reset while holding a result in DONE
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0,1,6'd3,0);
    end
    @(negedge clk);
    drive(0,0,6'd0,0);
    #1;
    chk_state("pre_rst", 6'd12,0, 6'd12,0, 3'd4,1);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 6'd0,0, 6'd0,0, 3'd0,0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(rdy0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0,1,6'd1,0);
    end
    @(negedge clk);
    drive(0,0,6'd0,0);
    #1;
    chk_state("post_rst_batch", 6'd4,0, 6'd4,0, 3'd4,1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop so the bench can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
